// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module : dmem_pkg
// Brief  : Shared types and widths for the data-memory responder.
// Rev    : 1.0
// ============================================================================
package dmem_pkg;

  localparam int DMEM_WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_RD  = 2'd0,
    OP_WR  = 2'd1,
    OP_ERR = 2'd2
  } op_t;

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module : dmem_array
// Brief  : Single-port synchronous word array, one read or write per cycle.
// Rev    : 1.0
// ============================================================================
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS = 13
) (
  input  logic                   clk,
  input  logic                   i_en,
  input  logic                   i_we,
  input  logic [ADDR_BITS-1:0]   i_addr,
  input  logic [DMEM_WORD_W-1:0] i_wdata,
  output logic [DMEM_WORD_W-1:0] o_rdata,
  input  logic                   i_createdump
);

  logic [DMEM_WORD_W-1:0] r_mem [2**ADDR_BITS];
  logic [DMEM_WORD_W-1:0] r_rdata;

  // Contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

  // Dump hook has no functional effect in the synthesizable model.
  logic w_unusedDump;
  assign w_unusedDump = i_createdump;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module : dmem_responder
// Brief  : MEM-stage data-memory responder with miss latency and a one-entry
//          last-access buffer for single-cycle read hits.
// Rev    : 1.0
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY   = 4,
  parameter int ADDR_BITS = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            Addr,
  input  logic [DMEM_WORD_W-1:0] DataIn,
  input  logic                   Rd,
  input  logic                   Wr,
  input  logic                   createdump,
  output logic [DMEM_WORD_W-1:0] DataOut,
  output logic                   Done,
  output logic                   Stall,
  output logic                   CacheHit,
  output logic                   err
);

  localparam int c_CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 2);

  state_t                 r_state;
  state_t                 w_nextState;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [14:0]            r_addr;
  logic [DMEM_WORD_W-1:0] r_data;
  op_t                    r_op;
  logic                   r_hit;
  logic                   r_done;
  logic                   r_bufValid;
  logic [14:0]            r_bufTag;
  logic [DMEM_WORD_W-1:0] r_bufData;

  logic                   w_req;
  logic                   w_reqErr;
  logic                   w_reqHit;
  logic                   w_arrEn;
  logic                   w_arrWe;
  logic [DMEM_WORD_W-1:0] w_arrRdata;
  logic [DMEM_WORD_W-1:0] w_rdData;

  assign w_req    = Rd | Wr;
  assign w_reqErr = (Rd & Wr) | Addr[0];
  assign w_reqHit = Rd & ~w_reqErr & r_bufValid & (r_bufTag == Addr[15:1]);

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_nextState = (w_reqErr | w_reqHit) ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (r_cnt == '0) begin
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_done     <= 1'b0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_op       <= OP_RD;
      r_hit      <= 1'b0;
      r_bufValid <= 1'b0;
      r_bufTag   <= '0;
      r_bufData  <= '0;
    end else begin
      r_state <= w_nextState;
      r_done  <= (w_nextState == ST_DONE);
      if (r_state == ST_IDLE && w_req) begin
        r_addr <= Addr[15:1];
        r_data <= DataIn;
        r_op   <= w_reqErr ? OP_ERR : (Wr ? OP_WR : OP_RD);
        r_hit  <= w_reqHit;
        r_cnt  <= c_CNT_LOAD;
      end
      if (r_state == ST_BUSY && r_cnt != '0) begin
        r_cnt <= r_cnt - c_CNT_W'(1);
      end
      // Buffer tracks the last successful access, write or read.
      if (r_state == ST_DONE && r_op != OP_ERR) begin
        r_bufValid <= 1'b1;
        r_bufTag   <= r_addr;
        r_bufData  <= (r_op == OP_WR) ? r_data : w_rdData;
      end
    end
  end

  // Read fetched in the last BUSY cycle; write commits on the DONE edge.
  assign w_arrWe = (r_state == ST_DONE) && (r_op == OP_WR);
  assign w_arrEn = w_arrWe ||
                   ((r_state == ST_BUSY) && (r_cnt == '0) && (r_op == OP_RD));

  dmem_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .clk         (clk),
    .i_en        (w_arrEn),
    .i_we        (w_arrWe),
    .i_addr      (r_addr[ADDR_BITS-1:0]),
    .i_wdata     (r_data),
    .o_rdata     (w_arrRdata),
    .i_createdump(createdump)
  );

  assign w_rdData = r_hit ? r_bufData : w_arrRdata;

  assign Done     = r_done;
  assign DataOut  = (r_done && r_op == OP_RD) ? w_rdData : '0;
  assign CacheHit = r_done & r_hit;
  assign err      = r_done & (r_op == OP_ERR);
  assign Stall    = rst & (((r_state == ST_IDLE) & w_req) | (r_state == ST_BUSY));

endmodule
`default_nettype wire
